// File: rtl/z80_prefix_fetch_if.sv
// Byte-in / record-out bundle for the Z80 prefix fetch stage.
// Carries the opcode byte handshake and the decoded instruction record.
// slave = the fetch stage itself, master = whoever drives bytes and drains records.
interface z80_prefix_fetch_if;
  logic [7:0] i_byte;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] o_op;
  logic       o_ix;
  logic       o_iy;
  logic       o_ed;
  logic       o_cb;
  logic [7:0] o_disp;
  logic [2:0] o_len;
  logic       o_valid;
  logic       i_out_ready;
  logic       o_m1;
  logic       o_int_ok;

  modport slave (
    input  i_byte, i_valid, i_out_ready,
    output o_ready, o_op, o_ix, o_iy, o_ed, o_cb, o_disp, o_len, o_valid, o_m1, o_int_ok
  );

  modport master (
    output i_byte, i_valid, i_out_ready,
    input  o_ready, o_op, o_ix, o_iy, o_ed, o_cb, o_disp, o_len, o_valid, o_m1, o_int_ok
  );
endinterface

// File: rtl/z80_prefix_fetch.sv
// Folds Z80 DD/FD/ED/CB prefix bytes into one decoded opcode record.
// Latency: the record is valid the cycle after its final byte is accepted.
// Backpressure: o_ready = !o_valid | i_out_ready; a held record stalls byte intake.
module z80_prefix_fetch (
  input  logic              i_clk,
  input  logic              i_reset_btn,
  z80_prefix_fetch_if.slave bus
);

  localparam logic [7:0] PFX_DD = 8'hDD;
  localparam logic [7:0] PFX_FD = 8'hFD;
  localparam logic [7:0] PFX_ED = 8'hED;
  localparam logic [7:0] PFX_CB = 8'hCB;

  typedef enum logic [2:0] {
    ST_NONE     = 3'd0,
    ST_IDX      = 3'd1,
    ST_ED       = 3'd2,
    ST_CB       = 3'd3,
    ST_IDXCB_D  = 3'd4,
    ST_IDXCB_OP = 3'd5
  } state_t;

  // Prefix-tracking state
  state_t     state_q;
  logic [2:0] cnt_q;        // bytes of the current instruction already consumed
  logic       ix_pend_q;
  logic       iy_pend_q;
  logic [7:0] disp_pend_q;

  // Registered output record
  logic [7:0] op_q;
  logic       ix_q;
  logic       iy_q;
  logic       ed_q;
  logic       cb_q;
  logic [7:0] disp_q;
  logic [2:0] len_q;
  logic       valid_q;
  logic       m1_q;
  logic       int_ok_q;

  // Combinational decode of the incoming byte
  logic       ready_d;
  logic       take_d;
  logic       is_dd_d;
  logic       is_fd_d;
  logic       is_ed_d;
  logic       is_cb_d;
  logic       is_pfx_d;
  logic       final_d;
  logic       emit_d;
  logic       m1_d;
  logic       e_ix_d;
  logic       e_iy_d;
  logic       e_ed_d;
  logic       e_cb_d;
  logic [7:0] e_disp_d;
  logic [2:0] len_d;

  // A held record only blocks intake while downstream refuses it, so a
  // draining record and a new byte can both move on the same edge.
  assign ready_d  = ~valid_q | bus.i_out_ready;
  assign take_d   = bus.i_valid & ready_d;

  assign is_dd_d  = (bus.i_byte == PFX_DD);
  assign is_fd_d  = (bus.i_byte == PFX_FD);
  assign is_ed_d  = (bus.i_byte == PFX_ED);
  assign is_cb_d  = (bus.i_byte == PFX_CB);
  assign is_pfx_d = is_dd_d | is_fd_d | is_ed_d | is_cb_d;

  // Length including the byte now being taken; long runs of dropped
  // DD/FD prefixes clamp at the 3-bit maximum.
  assign len_d    = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;

  assign emit_d   = take_d & final_d;

  // Decide whether the incoming byte closes the instruction and which
  // prefix fields the emitted record would carry.
  always_comb begin
    final_d  = 1'b0;
    m1_d     = 1'b0;
    e_ix_d   = 1'b0;
    e_iy_d   = 1'b0;
    e_ed_d   = 1'b0;
    e_cb_d   = 1'b0;
    e_disp_d = 8'h00;
    case (state_q)
      ST_NONE: begin
        final_d = ~is_pfx_d;
        m1_d    = take_d;
      end
      ST_IDX: begin
        final_d = ~is_pfx_d;
        m1_d    = take_d;
        e_ix_d  = ix_pend_q;
        e_iy_d  = iy_pend_q;
      end
      ST_ED: begin
        // Byte after ED is the opcode whatever its value.
        final_d = 1'b1;
        m1_d    = take_d;
        e_ed_d  = 1'b1;
      end
      ST_CB: begin
        final_d = 1'b1;
        m1_d    = take_d;
        e_cb_d  = 1'b1;
      end
      ST_IDXCB_D: begin
        // Displacement byte is a plain memory read, not an opcode fetch.
        final_d = 1'b0;
      end
      ST_IDXCB_OP: begin
        final_d  = 1'b1;
        e_ix_d   = ix_pend_q;
        e_iy_d   = iy_pend_q;
        e_cb_d   = 1'b1;
        e_disp_d = disp_pend_q;
      end
      default: begin
        final_d = 1'b0;
      end
    endcase
  end

  // Prefix FSM with registered output record, M1 pulse and interrupt window.
  always_ff @(posedge i_clk or posedge i_reset_btn) begin
    if (i_reset_btn) begin
      state_q     <= ST_NONE;
      cnt_q       <= 3'd0;
      ix_pend_q   <= 1'b0;
      iy_pend_q   <= 1'b0;
      disp_pend_q <= 8'h00;
      op_q        <= 8'h00;
      ix_q        <= 1'b0;
      iy_q        <= 1'b0;
      ed_q        <= 1'b0;
      cb_q        <= 1'b0;
      disp_q      <= 8'h00;
      len_q       <= 3'd0;
      valid_q     <= 1'b0;
      m1_q        <= 1'b0;
      int_ok_q    <= 1'b1;
    end else begin
      m1_q <= m1_d;
      if (emit_d) begin
        op_q        <= bus.i_byte;
        ix_q        <= e_ix_d;
        iy_q        <= e_iy_d;
        ed_q        <= e_ed_d;
        cb_q        <= e_cb_d;
        disp_q      <= e_disp_d;
        len_q       <= len_d;
        valid_q     <= 1'b1;
        state_q     <= ST_NONE;
        cnt_q       <= 3'd0;
        ix_pend_q   <= 1'b0;
        iy_pend_q   <= 1'b0;
        disp_pend_q <= 8'h00;
        int_ok_q    <= 1'b1;
      end else begin
        if (bus.i_out_ready) begin
          valid_q <= 1'b0;
        end
        if (take_d) begin
          // Any non-final byte leaves us mid-instruction.
          cnt_q    <= len_d;
          int_ok_q <= 1'b0;
          case (state_q)
            ST_NONE, ST_IDX: begin
              if (is_dd_d) begin
                ix_pend_q <= 1'b1;
                iy_pend_q <= 1'b0;
                state_q   <= ST_IDX;
              end else if (is_fd_d) begin
                ix_pend_q <= 1'b0;
                iy_pend_q <= 1'b1;
                state_q   <= ST_IDX;
              end else if (is_ed_d) begin
                // ED cancels any pending index prefix.
                ix_pend_q <= 1'b0;
                iy_pend_q <= 1'b0;
                state_q   <= ST_ED;
              end else if (is_cb_d) begin
                state_q <= (state_q == ST_IDX) ? ST_IDXCB_D : ST_CB;
              end
            end
            ST_IDXCB_D: begin
              disp_pend_q <= bus.i_byte;
              state_q     <= ST_IDXCB_OP;
            end
            default: begin
              state_q <= ST_NONE;
            end
          endcase
        end
      end
    end
  end

  assign bus.o_ready  = ready_d;
  assign bus.o_op     = op_q;
  assign bus.o_ix     = ix_q;
  assign bus.o_iy     = iy_q;
  assign bus.o_ed     = ed_q;
  assign bus.o_cb     = cb_q;
  assign bus.o_disp   = disp_q;
  assign bus.o_len    = len_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_m1     = m1_q;
  assign bus.o_int_ok = int_ok_q;

endmodule

// File: tb/tb_z80_prefix_fetch.sv
// Bench for z80_prefix_fetch: directed prefix sequences plus randomized
// byte streams checked against an instruction-level parser of the stream.
`timescale 1ns/1ps
module tb_z80_prefix_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  z80_prefix_fetch_if bus();

  z80_prefix_fetch dut (
    .i_clk       (clk),
    .i_reset_btn (rst),
    .bus         (bus)
  );

  typedef struct packed {
    logic [7:0] op;
    logic       ix;
    logic       iy;
    logic       ed;
    logic       cb;
    logic [7:0] disp;
    logic [2:0] len;
  } rec_t;

  typedef struct {
    bit acc;
    int bidx;
    bit m1;
    int consumed;
    bit int_ok;
  } cyc_t;

  int tests = 0;
  int fails = 0;

  logic [7:0] stim_q[$];
  rec_t       obs_q[$];
  rec_t       exp_q[$];
  cyc_t       log_q[$];
  bit         m1flag_q[$];
  bit         bound_q[$];
  bit         timed_out;
  int         hold_viol;
  int         ready_viol;

  function automatic rec_t cur_rec();
    rec_t r;
    r.op   = bus.o_op;
    r.ix   = bus.o_ix;
    r.iy   = bus.o_iy;
    r.ed   = bus.o_ed;
    r.cb   = bus.o_cb;
    r.disp = bus.o_disp;
    r.len  = bus.o_len;
    return r;
  endfunction

  function automatic string rec_str(input rec_t r);
    return $sformatf("op=%02h ix=%0b iy=%0b ed=%0b cb=%0b disp=%02h len=%0d",
                     r.op, r.ix, r.iy, r.ed, r.cb, r.disp, r.len);
  endfunction

  function automatic rec_t mk(input logic [7:0] op, input bit ix, input bit iy,
                              input bit ed, input bit cb, input logic [7:0] disp,
                              input int len);
    rec_t r;
    r.op = op; r.ix = ix; r.iy = iy; r.ed = ed; r.cb = cb; r.disp = disp;
    r.len = 3'(len);
    return r;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_out_ready = 1'b1;
    bus.i_byte = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Instruction-level reference: walks the byte stream as a Z80 decoder
  // would and lists the records, which bytes are opcode fetches, and
  // which byte counts fall on instruction boundaries.
  task automatic build_model();
    int   i;
    int   n;
    int   start;
    int   nb;
    rec_t r;
    n = stim_q.size();
    i = 0;
    exp_q.delete(); m1flag_q.delete(); bound_q.delete();
    for (int k = 0; k < n; k++) m1flag_q.push_back(1'b1);
    for (int k = 0; k <= n; k++) bound_q.push_back(1'b0);
    bound_q[0] = 1'b1;
    while (i < n) begin
      start = i;
      r = '0;
      while (i < n && (stim_q[i] == 8'hDD || stim_q[i] == 8'hFD)) begin
        r.ix = (stim_q[i] == 8'hDD);
        r.iy = (stim_q[i] == 8'hFD);
        i++;
      end
      if (i >= n) break;
      if (stim_q[i] == 8'hED) begin
        r.ix = 1'b0; r.iy = 1'b0; r.ed = 1'b1;
        i++;
      end else if (stim_q[i] == 8'hCB) begin
        r.cb = 1'b1;
        i++;
        if (r.ix || r.iy) begin
          if (i + 1 >= n) break;
          m1flag_q[i] = 1'b0;
          r.disp = stim_q[i];
          i++;
          m1flag_q[i] = 1'b0;
        end
      end
      if (i >= n) break;
      r.op = stim_q[i];
      i++;
      nb = i - start;
      r.len = (nb > 7) ? 3'd7 : 3'(nb);
      bound_q[i] = 1'b1;
      exp_q.push_back(r);
    end
  endtask

  // Feeds stim_q with random valid/ready gaps and records what comes out.
  task automatic run_stream(input int rdy_pct, input int vld_pct, input int limit);
    int   idx;
    int   cyc;
    bit   acc;
    bit   hold;
    rec_t held;
    cyc_t c;
    idx = 0; cyc = 0;
    obs_q.delete(); log_q.delete();
    hold_viol = 0; ready_viol = 0; timed_out = 1'b0;
    while ((idx < stim_q.size() || bus.o_valid) && cyc < limit) begin
      @(negedge clk);
      bus.i_out_ready = ($urandom_range(99) < rdy_pct);
      if (idx < stim_q.size() && $urandom_range(99) < vld_pct) begin
        bus.i_valid = 1'b1;
        bus.i_byte  = stim_q[idx];
      end else begin
        bus.i_valid = 1'b0;
        bus.i_byte  = 8'($urandom);
      end
      #1;
      if (bus.o_ready !== (!bus.o_valid || bus.i_out_ready)) ready_viol++;
      acc  = bus.i_valid && bus.o_ready;
      if (bus.o_valid && bus.i_out_ready) obs_q.push_back(cur_rec());
      hold = bus.o_valid && !bus.i_out_ready;
      held = cur_rec();
      @(posedge clk); #1;
      c.acc  = acc;
      c.bidx = idx;
      c.m1   = bus.o_m1;
      if (acc) idx++;
      c.consumed = idx;
      c.int_ok   = bus.o_int_ok;
      log_q.push_back(c);
      if (hold && (bus.o_valid !== 1'b1 || cur_rec() !== held)) hold_viol++;
      cyc++;
    end
    bus.i_valid = 1'b0;
    timed_out = (idx < stim_q.size()) || (bus.o_valid === 1'b1);
  endtask

  task automatic test_reset();
    apply_reset();
    @(posedge clk); #1;
    tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.o_valid); end
    tests++; if (bus.o_op !== 8'h00) begin fails++; $display("FAIL reset_op got %02h want 00", bus.o_op); end
    tests++; if ({bus.o_ix, bus.o_iy, bus.o_ed, bus.o_cb} !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b want 0000", {bus.o_ix, bus.o_iy, bus.o_ed, bus.o_cb}); end
    tests++; if (bus.o_disp !== 8'h00 || bus.o_len !== 3'd0) begin fails++; $display("FAIL reset_disp_len got disp=%02h len=%0d want 00/0", bus.o_disp, bus.o_len); end
    tests++; if (bus.o_m1 !== 1'b0 || bus.o_int_ok !== 1'b1) begin fails++; $display("FAIL reset_m1_int got m1=%b int_ok=%b want 0/1", bus.o_m1, bus.o_int_ok); end
    tests++; if (bus.o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.o_ready); end
  endtask

  task automatic test_fd00();
    rec_t e;
    int   m1c;
    int   zc;
    apply_reset();
    stim_q = '{8'hFD, 8'h00};
    run_stream(100, 100, 50);
    e = mk(8'h00, 0, 1, 0, 0, 8'h00, 2);
    m1c = 0; zc = 0;
    foreach (log_q[k]) begin m1c += int'(log_q[k].m1); zc += int'(!log_q[k].int_ok); end
    tests++; if (obs_q.size() != 1) begin fails++; $display("FAIL fd00_count got %0d want 1", obs_q.size()); end
    tests++; if (obs_q.size() < 1 || obs_q[0] !== e) begin fails++; $display("FAIL fd00_rec got %s want %s", (obs_q.size() > 0) ? rec_str(obs_q[0]) : "none", rec_str(e)); end
    tests++; if (m1c != 2) begin fails++; $display("FAIL fd00_m1 got %0d want 2", m1c); end
    tests++; if (zc != 1) begin fails++; $display("FAIL fd00_intok_low_cycles got %0d want 1", zc); end
  endtask

  task automatic test_last_index_wins();
    rec_t e;
    int   m1c;
    apply_reset();
    stim_q = '{8'hDD, 8'hFD, 8'h21};
    run_stream(100, 100, 50);
    e = mk(8'h21, 0, 1, 0, 0, 8'h00, 3);
    m1c = 0;
    foreach (log_q[k]) m1c += int'(log_q[k].m1);
    tests++; if (obs_q.size() != 1 || obs_q[0] !== e) begin fails++; $display("FAIL ddfd21_rec got n=%0d %s want %s", obs_q.size(), (obs_q.size() > 0) ? rec_str(obs_q[0]) : "none", rec_str(e)); end
    tests++; if (m1c != 3) begin fails++; $display("FAIL ddfd21_m1 got %0d want 3", m1c); end
  endtask

  task automatic test_idx_cb();
    rec_t e;
    int   m1c;
    apply_reset();
    stim_q = '{8'hFD, 8'hCB, 8'h05, 8'h46};
    run_stream(100, 100, 50);
    e = mk(8'h46, 0, 1, 0, 1, 8'h05, 4);
    m1c = 0;
    foreach (log_q[k]) m1c += int'(log_q[k].m1);
    tests++; if (obs_q.size() != 1 || obs_q[0] !== e) begin fails++; $display("FAIL fdcb_rec got n=%0d %s want %s", obs_q.size(), (obs_q.size() > 0) ? rec_str(obs_q[0]) : "none", rec_str(e)); end
    tests++; if (m1c != 2) begin fails++; $display("FAIL fdcb_m1 got %0d want 2", m1c); end
  endtask

  task automatic test_ed_forms();
    rec_t e0;
    rec_t e1;
    apply_reset();
    stim_q = '{8'hDD, 8'hED, 8'hB0, 8'hED, 8'hDD};
    run_stream(100, 100, 50);
    e0 = mk(8'hB0, 0, 0, 1, 0, 8'h00, 3);
    e1 = mk(8'hDD, 0, 0, 1, 0, 8'h00, 2);
    tests++; if (obs_q.size() != 2) begin fails++; $display("FAIL ed_count got %0d want 2", obs_q.size()); end
    tests++; if (obs_q.size() < 1 || obs_q[0] !== e0) begin fails++; $display("FAIL ddedb0_rec got %s want %s", (obs_q.size() > 0) ? rec_str(obs_q[0]) : "none", rec_str(e0)); end
    tests++; if (obs_q.size() < 2 || obs_q[1] !== e1) begin fails++; $display("FAIL eddd_rec got %s want %s", (obs_q.size() > 1) ? rec_str(obs_q[1]) : "none", rec_str(e1)); end
  endtask

  task automatic test_len_saturate();
    rec_t e;
    int   m1c;
    apply_reset();
    stim_q = '{8'hDD, 8'hFD, 8'hDD, 8'hFD, 8'hDD, 8'hFD, 8'hCB, 8'h12, 8'h34};
    run_stream(100, 100, 60);
    e = mk(8'h34, 0, 1, 0, 1, 8'h12, 7);
    m1c = 0;
    foreach (log_q[k]) m1c += int'(log_q[k].m1);
    tests++; if (obs_q.size() != 1 || obs_q[0] !== e) begin fails++; $display("FAIL saturate_rec got n=%0d %s want %s", obs_q.size(), (obs_q.size() > 0) ? rec_str(obs_q[0]) : "none", rec_str(e)); end
    tests++; if (m1c != 7) begin fails++; $display("FAIL saturate_m1 got %0d want 7", m1c); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    @(negedge clk);
    bus.i_out_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_byte = 8'h00;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.i_byte = 8'h3E;
      #1;
      tests++; if (bus.o_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_low[%0d] got %b want 0", c, bus.o_ready); end
      @(posedge clk); #1;
      tests++; if (bus.o_valid !== 1'b1 || bus.o_op !== 8'h00 || bus.o_len !== 3'd1) begin fails++; $display("FAIL bp_hold[%0d] got valid=%b %s want valid=1 op=00 len=1", c, bus.o_valid, rec_str(cur_rec())); end
    end
    @(negedge clk);
    bus.i_out_ready = 1'b1;
    #1;
    tests++; if (bus.o_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_drain got %b want 1", bus.o_ready); end
    @(posedge clk); #1;
    tests++; if (bus.o_valid !== 1'b1 || cur_rec() !== mk(8'h3E, 0, 0, 0, 0, 8'h00, 1)) begin fails++; $display("FAIL bp_next_rec got valid=%b %s want op=3e len=1", bus.o_valid, rec_str(cur_rec())); end
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got %b want 0", bus.o_valid); end
  endtask

  task automatic test_reset_mid();
    rec_t e;
    apply_reset();
    stim_q = '{8'hFD, 8'hCB};
    run_stream(100, 100, 50);
    tests++; if (bus.o_int_ok !== 1'b0) begin fails++; $display("FAIL midpfx_intok got %b want 0", bus.o_int_ok); end
    apply_reset();
    @(posedge clk); #1;
    tests++; if (bus.o_valid !== 1'b0 || cur_rec() !== '0 || bus.o_int_ok !== 1'b1 || bus.o_m1 !== 1'b0) begin fails++; $display("FAIL midpfx_reset got valid=%b int_ok=%b m1=%b %s", bus.o_valid, bus.o_int_ok, bus.o_m1, rec_str(cur_rec())); end
    // Reset while a record is stuck waiting for downstream.
    @(negedge clk);
    bus.i_out_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_byte = 8'h3C;
    @(posedge clk); #1;
    tests++; if (bus.o_valid !== 1'b1) begin fails++; $display("FAIL held_before_reset got %b want 1", bus.o_valid); end
    apply_reset();
    @(posedge clk); #1;
    tests++; if (bus.o_valid !== 1'b0 || bus.o_op !== 8'h00) begin fails++; $display("FAIL held_reset got valid=%b op=%02h want 0/00", bus.o_valid, bus.o_op); end
    stim_q = '{8'h76};
    run_stream(100, 100, 50);
    e = mk(8'h76, 0, 0, 0, 0, 8'h00, 1);
    tests++; if (obs_q.size() != 1 || obs_q[0] !== e) begin fails++; $display("FAIL post_reset_76 got n=%0d %s want %s", obs_q.size(), (obs_q.size() > 0) ? rec_str(obs_q[0]) : "none", rec_str(e)); end
  endtask

  task automatic test_random();
    int rdy_tab[4] = '{100, 50, 20, 90};
    int vld_tab[4] = '{100, 70, 90, 30};
    int r;
    int nmin;
    bit exp_m1;
    for (int run = 0; run < 4; run++) begin
      stim_q.delete();
      for (int k = 0; k < 150; k++) begin
        r = $urandom_range(9);
        case (r)
          0, 1:    stim_q.push_back(8'hDD);
          2, 3:    stim_q.push_back(8'hFD);
          4:       stim_q.push_back(8'hED);
          5:       stim_q.push_back(8'hCB);
          default: stim_q.push_back(8'($urandom));
        endcase
      end
      for (int k = 0; k < 3; k++) stim_q.push_back(8'h00);
      build_model();
      apply_reset();
      run_stream(rdy_tab[run], vld_tab[run], 5000);
      tests++; if (timed_out) begin fails++; $display("FAIL rnd%0d_timeout stream not drained within budget", run); end
      tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL rnd%0d_count got %0d want %0d", run, obs_q.size(), exp_q.size()); end
      nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int k = 0; k < nmin; k++) begin
        tests++;
        if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL rnd%0d_rec[%0d] got %s want %s", run, k, rec_str(obs_q[k]), rec_str(exp_q[k])); end
      end
      foreach (log_q[k]) begin
        exp_m1 = log_q[k].acc ? m1flag_q[log_q[k].bidx] : 1'b0;
        tests++;
        if (log_q[k].m1 != exp_m1) begin fails++; $display("FAIL rnd%0d_m1 cyc=%0d got %0b want %0b", run, k, log_q[k].m1, exp_m1); end
        tests++;
        if (log_q[k].int_ok != bound_q[log_q[k].consumed]) begin fails++; $display("FAIL rnd%0d_intok cyc=%0d got %0b want %0b", run, k, log_q[k].int_ok, bound_q[log_q[k].consumed]); end
      end
      tests++; if (hold_viol != 0) begin fails++; $display("FAIL rnd%0d_hold got %0d unstable cycles want 0", run, hold_viol); end
      tests++; if (ready_viol != 0) begin fails++; $display("FAIL rnd%0d_ready got %0d bad cycles want 0", run, ready_viol); end
    end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_out_ready = 1'b1;
    bus.i_byte = 8'h00;
    test_reset();
    test_fd00();
    test_last_index_wins();
    test_idx_cb();
    test_ed_forms();
    test_len_saturate();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
